hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter DM_WAIT, default 2: extra EX-stage cycles per data-memory access; 0 disables memory stalls.
REQ-002 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 SHALL have port clk  in  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-005 SHALL have ports ID_RS_A, ID_RS_B  in  5 each: source register addresses of the instruction in ID.
REQ-006 SHALL have ports ID_USES_A, ID_USES_B  in  1 each: the ID instruction reads the matching source.
REQ-007 SHALL have port EX_RD  in  5: destination register of the instruction in EX.
REQ-008 SHALL have port EX_RF_WE  in  1: the EX instruction writes the register file.
REQ-009 SHALL have port EX_IS_LOAD  in  1: the EX instruction is a load.
REQ-010 SHALL have port EX_DM_REQ  in  1: the EX instruction is a load or store.
REQ-011 SHALL have ports EX_NEXT_PC, EX_ret_enable  in  1 each: taken branch/jump or return resolved in EX (redirect).
REQ-012 SHALL have port PC_EN  out  1: PC register load enable.
REQ-013 SHALL have ports IF_ID_EN, ID_EX_EN  out  1 each: pipeline register load enables.
REQ-014 SHALL have ports IF_ID_FLUSH, ID_EX_FLUSH  out  1 each: load a NOP/bubble; flush dominates enable.
REQ-015 SHALL have port DM_BUSY  out  1: high while a memory stall is in progress.
REQ-016 SHALL have port STATE  out  2: RUN=0, MEM_WAIT=1, FLUSH=2; 3 unused.
REQ-017 SHALL have ports STALL_CNT, FLUSH_CNT  out  CNT_W each: performance counters.

Function
REQ-018 SHALL compute hazard = EX_IS_LOAD & EX_RF_WE & (EX_RD!=0) & ((ID_USES_A & ID_RS_A==EX_RD) | (ID_USES_B & ID_RS_B==EX_RD)); register 0 never hazards.
REQ-019 SHALL compute redirect = EX_NEXT_PC | EX_ret_enable.
REQ-020 SHALL generate all control outputs combinationally from state, wait counter and inputs; state and counters are registered.
REQ-021 In RUN with EX_DM_REQ=1 and DM_WAIT>0, SHALL drive all enables 0 and flushes 0, load wcnt=DM_WAIT-1, go to MEM_WAIT; this rule has highest priority.
REQ-022 In RUN with no memory entry and redirect=1, SHALL drive PC_EN=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1, go to FLUSH; redirect beats hazard.
REQ-023 In RUN with only hazard=1, SHALL drive PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1, stay in RUN (one bubble per hazard).
REQ-024 In RUN with no event, SHALL drive PC_EN=IF_ID_EN=ID_EX_EN=1 and flushes 0.
REQ-025 In MEM_WAIT with wcnt>0, SHALL freeze (all enables 0, flushes 0), DM_BUSY=1, decrement wcnt.
REQ-026 In MEM_WAIT with wcnt=0 (release cycle), SHALL ignore EX_DM_REQ, apply REQ-022..024 to the same EX instruction, and go to FLUSH on redirect, else RUN; DM_BUSY=0.
REQ-027 A memory instruction SHALL occupy EX for exactly DM_WAIT+1 cycles; DM_WAIT=1 gives one freeze cycle.
REQ-028 In FLUSH (one cycle, covering synchronous IMEM read latency), SHALL drive PC_EN=1, IF_ID_EN=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1, ignore all inputs, go to RUN.
REQ-029 STALL_CNT SHALL increment on every cycle with PC_EN=0 outside reset, saturating at all-ones.
REQ-030 FLUSH_CNT SHALL increment once per entry into FLUSH, saturating at all-ones.
REQ-031 SHALL never enter state 3; if reached, SHALL behave as RUN and go to RUN next cycle.

Reset
REQ-032 While rst=1, SHALL drive PC_EN=0, IF_ID_EN=0, ID_EX_EN=0, IF_ID_FLUSH=1, ID_EX_FLUSH=1, DM_BUSY=0.
REQ-033 On a clock edge with rst=1, SHALL set STATE=RUN, wcnt=0, STALL_CNT=0, FLUSH_CNT=0, abandoning any MEM_WAIT/FLUSH in progress.
REQ-034 The first cycle after rst falls SHALL behave as RUN per REQ-021..024.

Verification
REQ-035 Load-use: EX_IS_LOAD=1, EX_RF_WE=1, EX_RD=5, ID_RS_A=5, ID_USES_A=1 -> one cycle PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1; STALL_CNT +1; EX_RD=0 -> no stall.
REQ-036 Memory stall, DM_WAIT=2: EX_DM_REQ=1 held -> enables 0 for 2 cycles, DM_BUSY=1 in second only, STATE 0,1,1 then 0; STALL_CNT +2.
REQ-037 Redirect: EX_NEXT_PC=1 one cycle -> two consecutive cycles IF_ID_FLUSH=1 and ID_EX_FLUSH=1 with PC_EN=1, STATE 0->2->0; FLUSH_CNT +1.
REQ-038 Simultaneous: EX_DM_REQ=1, EX_NEXT_PC=1, hazard=1 -> memory freeze first, redirect in release cycle, no hazard bubble.
REQ-039 Reset mid-MEM_WAIT: rst=1 for one edge during wcnt=1 -> STATE=0, counters 0, flush outputs 1 while rst=1; normal RUN next cycle.
REQ-040 Saturation: CNT_W=4, 20 hazard cycles -> STALL_CNT stops at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle data-memory freezes and
// redirect flushes, plus saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned DM_WAIT = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_RS_A,
  input  logic [4:0]       ID_RS_B,
  input  logic             ID_USES_A,
  input  logic             ID_USES_B,
  input  logic [4:0]       EX_RD,
  input  logic             EX_RF_WE,
  input  logic             EX_IS_LOAD,
  input  logic             EX_DM_REQ,
  input  logic             EX_NEXT_PC,
  input  logic             EX_ret_enable,
  output logic             PC_EN,
  output logic             IF_ID_EN,
  output logic             ID_EX_EN,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             DM_BUSY,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  localparam int unsigned WW = $clog2(DM_WAIT + 2);
  localparam logic [WW-1:0] WLoad = WW'((DM_WAIT != 0) ? (DM_WAIT - 1) : 0);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2,
    StBad     = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic              hazard, redirect, apply_normal;

  assign hazard = EX_IS_LOAD & EX_RF_WE & (EX_RD != 5'd0) &
                  ((ID_USES_A & (ID_RS_A == EX_RD)) | (ID_USES_B & (ID_RS_B == EX_RD)));
  assign redirect = EX_NEXT_PC | EX_ret_enable;

  always_comb begin
    PC_EN        = 1'b1;
    IF_ID_EN     = 1'b1;
    ID_EX_EN     = 1'b1;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    DM_BUSY      = 1'b0;
    state_d      = StRun;
    wcnt_d       = wcnt_q;
    apply_normal = 1'b0;

    case (state_q)
      StMemWait: begin
        if (wcnt_q != '0) begin
          PC_EN    = 1'b0;
          IF_ID_EN = 1'b0;
          ID_EX_EN = 1'b0;
          DM_BUSY  = 1'b1;
          wcnt_d   = wcnt_q - WW'(1);
          state_d  = StMemWait;
        end else begin
          // Release cycle: the same EX instruction must not re-trigger a memory stall.
          apply_normal = 1'b1;
        end
      end
      StFlush: begin
        IF_ID_FLUSH = 1'b1;
        ID_EX_FLUSH = 1'b1;
        state_d     = StRun;
      end
      default: begin
        if (EX_DM_REQ && (DM_WAIT != 0)) begin
          PC_EN    = 1'b0;
          IF_ID_EN = 1'b0;
          ID_EX_EN = 1'b0;
          wcnt_d   = WLoad;
          state_d  = StMemWait;
        end else begin
          apply_normal = 1'b1;
        end
      end
    endcase

    if (apply_normal) begin
      if (redirect) begin
        IF_ID_FLUSH = 1'b1;
        ID_EX_FLUSH = 1'b1;
        state_d     = StFlush;
      end else if (hazard) begin
        PC_EN       = 1'b0;
        IF_ID_EN    = 1'b0;
        ID_EX_FLUSH = 1'b1;
      end
    end

    if (rst) begin
      PC_EN       = 1'b0;
      IF_ID_EN    = 1'b0;
      ID_EX_EN    = 1'b0;
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
      DM_BUSY     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (!PC_EN && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if ((state_d == StFlush) && (state_q != StFlush) && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign STATE     = state_q;
  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;

endmodule
